// File: rtl/instr_encoder.sv
// instr_encoder: packs field-level encode requests into 32-bit ARM words,
// queues them in a DEPTH-entry FIFO and writes them sequentially into imem.
// Build option: define ENC_BRANCH_ABS_EN to treat the branch imm24 field as
// an absolute word target, converted here to a PC+8 relative offset.
// Handshake: a transfer happens on a rising edge where valid (req_valid or
// imem_we) and ready (req_ready or imem_ready) are both high; imem_we never
// depends on imem_ready, req_ready only looks at occupancy and the pop.
module instr_encoder #(
   parameter int DEPTH = 4,
   parameter int AW    = 6
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          start,
   input  logic [AW-1:0] start_addr,
   input  logic          req_valid,
   output logic          req_ready,
   input  logic [1:0]    req_class,
   input  logic [3:0]    req_cond,
   input  logic [5:0]    req_funct,
   input  logic [3:0]    req_rn,
   input  logic [3:0]    req_rd,
   input  logic [11:0]   req_src2,
   input  logic [23:0]   req_imm24,
   output logic          imem_we,
   input  logic          imem_ready,
   output logic [AW-1:0] imem_addr,
   output logic [31:0]   imem_wdata,
   output logic [AW:0]   count,
   output logic          err,
   output logic          busy
);

   localparam int PW = $clog2(DEPTH);
   localparam logic [PW:0]   OCC_FULL = (PW+1)'(DEPTH);
   localparam logic [PW:0]   OCC_ONE  = (PW+1)'(1);
   localparam logic [PW-1:0] PTR_ONE  = PW'(1);
   localparam logic [AW-1:0] ADDR_ONE = AW'(1);
   localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
   localparam logic [AW:0]   CNT_MAX  = {1'b1, {AW{1'b0}}};

   logic [31:0]   mem_q [DEPTH];
   logic [31:0]   mem_d [DEPTH];
   logic [PW-1:0] wptr_q, wptr_d;
   logic [PW-1:0] rptr_q, rptr_d;
   logic [PW:0]   occ_q, occ_d;
   logic [AW-1:0] enc_addr_q, enc_addr_d;
   logic [AW-1:0] wr_addr_q, wr_addr_d;
   logic [AW:0]   count_q, count_d;
   logic          err_q, err_d;

   logic        empty, full, pop, accept, illegal, push;
   logic [23:0] br_off;
   logic [31:0] enc_word;

   assign empty   = (occ_q == '0);
   assign full    = (occ_q == OCC_FULL);
   // Writes are suppressed while reset or start is asserted so discarded
   // words never reach imem.
   assign imem_we   = reset & ~start & ~empty;
   assign pop       = imem_we & imem_ready;
   assign req_ready = reset & ~start & (~full | pop);
   assign accept    = req_valid & req_ready;
   assign illegal   = (req_class == 2'b11);
   assign push      = accept & ~illegal;

`ifdef ENC_BRANCH_ABS_EN
   // Branch target is absolute; the core reads PC+8, so bias by two words.
   assign br_off = req_imm24 - (24'(enc_addr_q) + 24'd2);
`else
   assign br_off = req_imm24;
`endif

   // Pack the request fields into the decoder's Op/Funct/Src2 layout.
   always_comb begin
      enc_word = {req_cond, req_class, req_funct, req_rn, req_rd, req_src2};
      if (req_class == 2'b10) begin
         enc_word = {req_cond, 3'b101, req_funct[4], br_off};
      end
   end

   // Next-state for FIFO, address counters, write count and error flag.
   always_comb begin
      mem_d      = mem_q;
      wptr_d     = wptr_q;
      rptr_d     = rptr_q;
      occ_d      = occ_q;
      enc_addr_d = enc_addr_q;
      wr_addr_d  = wr_addr_q;
      count_d    = count_q;
      err_d      = err_q;
      if (start) begin
         wptr_d     = '0;
         rptr_d     = '0;
         occ_d      = '0;
         enc_addr_d = start_addr;
         wr_addr_d  = start_addr;
         count_d    = '0;
         err_d      = 1'b0;
      end else begin
         if (push) begin
            mem_d[wptr_q] = enc_word;
            wptr_d        = wptr_q + PTR_ONE;
            enc_addr_d    = enc_addr_q + ADDR_ONE;
         end
         if (pop) begin
            rptr_d    = rptr_q + PTR_ONE;
            wr_addr_d = wr_addr_q + ADDR_ONE;
            if (count_q != CNT_MAX) begin
               count_d = count_q + CNT_ONE;
            end
         end
         if (push && !pop) begin
            occ_d = occ_q + OCC_ONE;
         end else if (pop && !push) begin
            occ_d = occ_q - OCC_ONE;
         end
         if (accept && illegal) begin
            err_d = 1'b1;
         end
      end
   end

   // State registers with synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!reset) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem_q[i] <= '0;
         end
         wptr_q     <= '0;
         rptr_q     <= '0;
         occ_q      <= '0;
         enc_addr_q <= '0;
         wr_addr_q  <= '0;
         count_q    <= '0;
         err_q      <= 1'b0;
      end else begin
         mem_q      <= mem_d;
         wptr_q     <= wptr_d;
         rptr_q     <= rptr_d;
         occ_q      <= occ_d;
         enc_addr_q <= enc_addr_d;
         wr_addr_q  <= wr_addr_d;
         count_q    <= count_d;
         err_q      <= err_d;
      end
   end

   assign imem_addr  = wr_addr_q;
   assign imem_wdata = empty ? 32'd0 : mem_q[rptr_q];
   assign count      = count_q;
   assign err        = err_q;
   assign busy       = ~empty;

endmodule

// File: tb/tb_instr_encoder.sv
// tb_instr_encoder: random and directed requests, a reference packer and a
// scoreboard queue of expected {address, word} pairs popped on each write.
module tb_instr_encoder;

   localparam int DEPTH = 4;
   localparam int AW    = 6;
   localparam int ASPAN = 1 << AW;

   logic          clk;
   logic          reset;
   logic          start;
   logic [AW-1:0] start_addr;
   logic          req_valid;
   logic          req_ready;
   logic [1:0]    req_class;
   logic [3:0]    req_cond;
   logic [5:0]    req_funct;
   logic [3:0]    req_rn;
   logic [3:0]    req_rd;
   logic [11:0]   req_src2;
   logic [23:0]   req_imm24;
   logic          imem_we;
   logic          imem_ready;
   logic [AW-1:0] imem_addr;
   logic [31:0]   imem_wdata;
   logic [AW:0]   count;
   logic          err;
   logic          busy;

   instr_encoder #(.DEPTH(DEPTH), .AW(AW)) dut (
      .clk(clk), .reset(reset), .start(start), .start_addr(start_addr),
      .req_valid(req_valid), .req_ready(req_ready), .req_class(req_class),
      .req_cond(req_cond), .req_funct(req_funct), .req_rn(req_rn),
      .req_rd(req_rd), .req_src2(req_src2), .req_imm24(req_imm24),
      .imem_we(imem_we), .imem_ready(imem_ready), .imem_addr(imem_addr),
      .imem_wdata(imem_wdata), .count(count), .err(err), .busy(busy)
   );

   // Clock and watchdog.
   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   int total = 0;
   int bad   = 0;
   logic [AW+31:0] exp_q[$];
   int   enc_addr_m = 0;
   int   count_m    = 0;
   logic err_m      = 1'b0;
   logic rand_ready_en = 1'b0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Reference packer: builds the word arithmetically from the field rules.
   function automatic logic [31:0] model_word(input logic [1:0] cls, input logic [3:0] cond,
                                              input logic [5:0] funct, input logic [3:0] rn,
                                              input logic [3:0] rd, input logic [11:0] src2,
                                              input logic [23:0] imm, input int addr);
      logic [31:0] w;
      longint off;
      if (cls == 2'd2) begin
`ifdef ENC_BRANCH_ABS_EN
         off = (longint'(imm) + 64'd16777216 - longint'(addr + 2)) % 16777216;
`else
         off = longint'(imm);
`endif
         w = (32'(cond) << 28) + (32'd5 << 25) + (32'(funct[4]) << 24) + 32'(off);
      end else begin
         w = (32'(cond) << 28) + (32'(cls) << 26) + (32'(funct) << 20)
           + (32'(rn) << 16) + (32'(rd) << 12) + 32'(src2);
      end
      return w;
   endfunction

   // Monitor: every granted write must match the oldest expected entry.
   always @(negedge clk) begin
      logic [AW+31:0] e;
      if (start === 1'b1) check("we_during_start", imem_we, 0);
      if (imem_we === 1'b1 && imem_ready === 1'b1 && reset === 1'b1 && start !== 1'b1) begin
         if (exp_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_write: addr %0d data %08h, nothing expected", imem_addr, imem_wdata);
         end else begin
            e = exp_q.pop_front();
            check("write_addr", imem_addr, e[AW+31:32]);
            check("write_data", imem_wdata, e[31:0]);
            if (count_m < ASPAN) count_m++;
         end
      end
   end

   // Random imem_ready generator used in the random phase.
   initial begin
      forever begin
         @(posedge clk);
         #1;
         if (rand_ready_en) imem_ready = 1'($urandom_range(0, 1));
      end
   end

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic do_start(input logic [AW-1:0] a);
      start      = 1'b1;
      start_addr = a;
      req_valid  = 1'b0;
      exp_q.delete();
      enc_addr_m = int'(a);
      count_m    = 0;
      err_m      = 1'b0;
      @(posedge clk);
      #1;
      start = 1'b0;
   endtask

   task automatic set_fields(input logic [1:0] cls, input logic [3:0] cond, input logic [5:0] funct,
                             input logic [3:0] rn, input logic [3:0] rd, input logic [11:0] src2,
                             input logic [23:0] imm);
      req_class = cls;
      req_cond  = cond;
      req_funct = funct;
      req_rn    = rn;
      req_rd    = rd;
      req_src2  = src2;
      req_imm24 = imm;
   endtask

   // Offer one request; on acceptance record the expected word (literal or model).
   task automatic send(input logic [1:0] cls, input logic [3:0] cond, input logic [5:0] funct,
                       input logic [3:0] rn, input logic [3:0] rd, input logic [11:0] src2,
                       input logic [23:0] imm, input logic use_lit, input logic [31:0] lit);
      logic [31:0] w;
      int t;
      logic acc;
      set_fields(cls, cond, funct, rn, rd, src2, imm);
      req_valid = 1'b1;
      acc = 1'b0;
      t = 0;
      while (!acc && t < 200) begin
         @(negedge clk);
         if (req_ready === 1'b1) acc = 1'b1;
         else t++;
      end
      if (acc) begin
         if (cls != 2'd3) begin
            w = use_lit ? lit : model_word(cls, cond, funct, rn, rd, src2, imm, enc_addr_m);
            exp_q.push_back({AW'(enc_addr_m), w});
            enc_addr_m = (enc_addr_m + 1) % ASPAN;
         end else begin
            err_m = 1'b1;
         end
      end else begin
         check("req_timeout", 0, 1);
      end
      @(posedge clk);
      #1;
      req_valid = 1'b0;
   endtask

   task automatic rand_send(input logic [1:0] cls);
      send(cls, 4'($urandom_range(0, 15)), 6'($urandom_range(0, 63)), 4'($urandom_range(0, 15)),
           4'($urandom_range(0, 15)), 12'($urandom_range(0, 4095)), 24'($urandom), 1'b0, 32'd0);
   endtask

   task automatic drain();
      int t;
      imem_ready = 1'b1;
      t = 0;
      while (exp_q.size() != 0 && t < 100) begin
         @(posedge clk);
         #1;
         t++;
      end
      if (exp_q.size() != 0) check("drain_timeout", exp_q.size(), 0);
      tick(1);
   endtask

   // Main stimulus.
   initial begin
      logic [31:0] w5;
      int r;
      reset = 1'b0; start = 1'b0; start_addr = '0; req_valid = 1'b0;
      set_fields(2'd0, 4'd0, 6'd0, 4'd0, 4'd0, 12'd0, 24'd0);
      imem_ready = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      @(negedge clk);
      check("rst_req_ready", req_ready, 0);
      check("rst_imem_we", imem_we, 0);
      check("rst_busy", busy, 0);
      check("rst_count", count, 0);
      check("rst_err", err, 0);
      check("rst_imem_addr", imem_addr, 0);
      check("rst_imem_wdata", imem_wdata, 0);
      @(posedge clk);
      #1;
      reset = 1'b1;

      // DP after reset, then LDR at the next address.
      imem_ready = 1'b1;
      send(2'd0, 4'hE, 6'b101000, 4'd1, 4'd2, 12'h005, 24'd0, 1'b1, 32'hE2812005);
      check("dp_we_next_cycle", imem_we, 1);
      check("dp_addr", imem_addr, 0);
      check("dp_data", imem_wdata, 32'hE2812005);
      tick(1);
      check("dp_count", count, 1);
      check("dp_busy_clear", busy, 0);
      send(2'd1, 4'hE, 6'b011001, 4'd0, 4'd3, 12'h004, 24'd0, 1'b1, 32'hE5903004);
      tick(1);
      check("ldr_count", count, 2);

      // Branch at start_addr 4.
      do_start(AW'(4));
`ifdef ENC_BRANCH_ABS_EN
      send(2'd2, 4'hE, 6'b000000, 4'd0, 4'd0, 12'd0, 24'd2, 1'b1, 32'hEAFFFFFC);
`else
      send(2'd2, 4'hE, 6'b000000, 4'd0, 4'd0, 12'd0, 24'hFFFFFC, 1'b1, 32'hEAFFFFFC);
`endif
      tick(1);
      check("branch_count", count, 1);

      // Backpressure: fill the FIFO, the fifth waits until a pop frees space.
      do_start(AW'(0));
      imem_ready = 1'b0;
      for (int i = 0; i < DEPTH; i++) rand_send(2'($urandom_range(0, 1)));
      check("full_busy", busy, 1);
      set_fields(2'd0, 4'hA, 6'h15, 4'd7, 4'd8, 12'h123, 24'd0);
      w5 = model_word(2'd0, 4'hA, 6'h15, 4'd7, 4'd8, 12'h123, 24'd0, enc_addr_m);
      req_valid = 1'b1;
      @(negedge clk);
      check("full_no_ready", req_ready, 0);
      @(posedge clk);
      #1;
      imem_ready = 1'b1;
      @(negedge clk);
      check("pop_gives_ready", req_ready, 1);
      exp_q.push_back({AW'(enc_addr_m), w5});
      enc_addr_m = (enc_addr_m + 1) % ASPAN;
      @(posedge clk);
      #1;
      req_valid = 1'b0;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         check("burst_we", imem_we, 1);
      end
      @(negedge clk);
      check("burst_idle", imem_we, 0);
      @(posedge clk);
      #1;
      check("burst_count", count, 5);

      // Illegal request between two DP requests.
      do_start(AW'(0));
      rand_send(2'd0);
      rand_send(2'd3);
      rand_send(2'd0);
      tick(3);
      check("illegal_err", err, 1);
      check("illegal_count", count, 2);

      // Start flushes queued words and clears err.
      do_start(AW'(10));
      imem_ready = 1'b0;
      for (int i = 0; i < 3; i++) rand_send(2'd0);
      rand_send(2'd3);
      tick(1);
      check("flush_pre_busy", busy, 1);
      check("flush_pre_err", err, 1);
      do_start(AW'(20));
      check("flush_busy", busy, 0);
      check("flush_count", count, 0);
      check("flush_err", err, 0);
      check("flush_we", imem_we, 0);
      imem_ready = 1'b1;
      rand_send(2'd0);
      tick(1);
      check("flush_next_count", count, 1);

      // Address wrap from 62.
      do_start(AW'(62));
      for (int i = 0; i < 4; i++) rand_send(2'($urandom_range(0, 2)));
      tick(2);
      check("wrap_count", count, 4);

      // Random traffic with random imem_ready and occasional start.
      rand_ready_en = 1'b1;
      for (int i = 0; i < 300; i++) begin
         r = int'($urandom_range(0, 99));
         if (r < 3) begin
            do_start(AW'($urandom_range(0, ASPAN - 1)));
         end else if (r < 8) begin
            rand_send(2'd3);
         end else begin
            rand_send(2'($urandom_range(0, 2)));
         end
      end
      rand_ready_en = 1'b0;
      drain();
      check("rand_count", count, count_m);
      check("rand_err", err, err_m);
      check("rand_busy", busy, 0);

      // Reset mid-stream discards queued words.
      imem_ready = 1'b0;
      rand_send(2'd0);
      rand_send(2'd0);
      reset = 1'b0;
      exp_q.delete();
      enc_addr_m = 0;
      count_m = 0;
      err_m = 1'b0;
      @(negedge clk);
      check("midrst_ready", req_ready, 0);
      @(posedge clk);
      #1;
      check("midrst_busy", busy, 0);
      check("midrst_count", count, 0);
      reset = 1'b1;
      imem_ready = 1'b1;
      rand_send(2'd1);
      tick(1);
      check("midrst_next_count", count, 1);
      check("final_queue_empty", exp_q.size(), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/instr_encoder.md
# instr_encoder

Streaming ARM instruction encoder: the write-side counterpart of the processor's instruction decoder. Accepts field-level encode requests (class, condition, funct, Rn, Rd, Src2 or branch target) over a valid/ready handshake, packs them into 32-bit words using the same Op/Funct/Src2 layout the decoder consumes, buffers them in a small FIFO, and writes them sequentially into instruction memory. It is used by the test loader and self-modifying-code experiments to build programs in imem without an external assembler.

## Interface
- `DEPTH`, 4: FIFO entries; power of two, at least 2.
- `AW`, 6: imem word-address width.
- `clk` in 1: sole clock; all state updates on the rising edge.
- `reset` in 1: synchronous, active-low reset.
- `start` in 1: one-cycle pulse; loads address counters from `start_addr`, flushes the FIFO, and clears `err` and `count`.
- `start_addr` in AW: first imem word address after `start`.
- `req_valid` in 1 / `req_ready` out 1: request handshake; transfer occurs when both are high.
- `req_class` in 2: 00 is DP, 01 is memory, 10 is branch, 11 is illegal.
- `req_cond` in 4: condition field, bits 31:28.
- `req_funct` in 6: bits 25:20 (I/cmd/S for DP; ~I,P,U,B,W,L for memory; funct[4] is the link bit for branch).
- `req_rn`, `req_rd` in 4: bits 19:16 and 15:12 (ignored for branch).
- `req_src2` in 12: bits 11:0 (ignored for branch).
- `req_imm24` in 24: branch offset or target (see Configuration).
- `imem_we` out 1 / `imem_ready` in 1: write request and grant; a write occurs when both are high.
- `imem_addr` out AW: address of the FIFO head word.
- `imem_wdata` out 32: FIFO head word.
- `count` out AW+1: words written since reset or `start`; saturates at 2^AW.
- `err` out 1: sticky illegal-request flag.
- `busy` out 1: FIFO non-empty.

## Operation
- Packing for DP and memory: {cond, class, funct, Rn, Rd, src2}. Packing for branch: {cond, 3'b101, funct[4], imm24}.
- An accepted legal request is packed combinationally and pushed into the FIFO on the same edge. `enc_addr`, the address that word will occupy, increments by 1 mod 2^AW.
- A class 11 request is consumed (ready high): `err` sets, nothing is pushed, and `enc_addr` is unchanged.
- `req_ready` = reset deasserted AND !`start` AND (FIFO not full OR a pop occurs this cycle).
- `imem_we` = FIFO non-empty; it is independent of `req_valid`.
- On each write (`imem_we` & `imem_ready`): pop, `wr_addr` += 1 mod 2^AW, `count` += 1 (saturating).
- Push and pop in the same cycle are allowed; occupancy is then unchanged.
- `start`: `enc_addr` = `wr_addr` = `start_addr`; FIFO emptied; pending words discarded unwritten; any request or write in that cycle is ignored. `start` has priority over everything except reset.
- Reset values: FIFO empty, `enc_addr` = `wr_addr` = 0, `count` = 0, `err` = 0, `imem_we` = 0, `busy` = 0, `req_ready` = 0 while reset is asserted, `imem_addr` = 0, `imem_wdata` = 0.
- Address wrap: 2^AW−1 is followed by 0, with no error raised.

## Timing
- Request accepted at edge k: `imem_we` is high in cycle k+1, with that word's `imem_addr` and `imem_wdata`.
- With `imem_ready` held high, sustained throughput is 1 word per cycle.
- A full FIFO with no pop drops `req_ready` in the same cycle (combinational from occupancy and `imem_ready`).
- `err`, `count`, and `busy` are registered and update on the edge after the causing event.
- Reset asserted mid-stream aborts it on the next edge; no further writes occur.

## Configuration
- `ENC_BRANCH_ABS_EN` defined: for branch, `req_imm24` is an absolute word target T (zero-extended). The encoder emits imm24 = (T − (`enc_addr` + 2)) mod 2^24, matching PC+8 semantics.
- `ENC_BRANCH_ABS_EN` undefined: `req_imm24` is copied verbatim; no adder is present.

## Test plan
- DP after reset: cond E, class 00, funct 101000, Rn 1, Rd 2, src2 0x005 → next cycle `imem_we`=1, addr 0, data 0xE2812005; `count`=1 after the write.
- LDR: cond E, class 01, funct 011001, Rn 0, Rd 3, src2 0x004 → data 0xE5903004 at the next sequential address.
- Branch, macro defined: `start` with `start_addr`=4, branch T=2, funct[4]=0 → addr 4, data 0xEAFFFFFC. Macro undefined: `req_imm24`=0xFFFFFC → same word.
- Backpressure with DEPTH=4: `imem_ready`=0, offer 5 requests → `req_ready` falls after the 4th. Raise `imem_ready` → writes at addr 0,1,2,3 on consecutive cycles, then the 5th at 4.
- Illegal class 11 between two DP requests → `err`=1, exactly 2 writes at addr 0 and 1.
- `start` with 3 words queued and `imem_ready`=0 → FIFO empty and `busy`=0 next cycle, `count`=0, no stale write. The next request is written at `start_addr`.
